step_level_selector: RTL and testbench
======================================

// Module: step_level_selector
// PURPOSE
//  Parametrised up/down level selector; successor to the fixed 0..8 speed-code counter.
//  Steps a bounded value on debounced up/down key presses: one step per press, with
//  configurable bounds, step size, saturate-or-wrap, and timed hold-to-repeat.
//  Sits between keyDebouncing outputs and display/LED consumers: speed, mode, pitch index.
// PARAMETERS
//  WIDTH         4   bit width of value
//  MIN_VAL       0   lowest legal value
//  MAX_VAL       8   highest legal value (MIN_VAL < MAX_VAL < 2**WIDTH)
//  RESET_VAL     3   value after reset / sync_clr (MIN_VAL..MAX_VAL)
//  STEP          1   increment per step (1..MAX_VAL-MIN_VAL)
//  WRAP          0   0 = saturate at bounds, 1 = wrap MAX_VAL<->MIN_VAL
//  REPEAT_DELAY  2   ticks a key is held before the first repeat (>=1)
//  REPEAT_PERIOD 1   ticks between subsequent repeats (>=1)
// PORTS
//  clk       in   1      system clock; all logic on posedge
//  rstN      in   1      asynchronous active-low reset
//  tick      in   1      1-cycle timing strobe (e.g. 4 Hz enable); paces repeat only
//  up        in   1      debounced level, synchronous to clk
//  down      in   1      debounced level, synchronous to clk
//  sync_clr  in   1      synchronous reload of RESET_VAL
//  value     out  WIDTH  current level
//  at_min    out  1      value == MIN_VAL (combinational from value)
//  at_max    out  1      value == MAX_VAL (combinational from value)
//  changed   out  1      1-cycle pulse in the cycle after value is updated
// BEHAVIOUR
//  Reset (rstN=0, async): value=RESET_VAL, changed=0, FSM=IDLE, repeat counter=0, edge regs=0.
//  Edge detection: registered up_q/down_q; press = level & ~level_q.
//  Priority per cycle: sync_clr > both-held > press > repeat step.
//   sync_clr: value<=RESET_VAL, FSM<=IDLE; changed=1 only if value differed.
//   up&down both high: no step; FSM<=IDLE.
//   Exactly one key rises: one step in that direction (value updates on that edge).
//    FSM<=DELAY, cnt<=REPEAT_DELAY.
//  FSM states: IDLE, DELAY, REPEAT (held direction in dir reg).
//   IDLE:   wait for press.
//   DELAY:  held key released -> IDLE.
//    tick & cnt==1 -> step, cnt<=REPEAT_PERIOD, ->REPEAT.
//    tick & cnt>1 -> cnt--.
//   REPEAT: held key released -> IDLE.
//    tick & cnt==1 -> step, cnt<=REPEAT_PERIOD.
//    tick & cnt>1 -> cnt--.
//   tick ignored in IDLE; no tick -> counter holds.
//  Step arithmetic in WIDTH+1 bits, no overflow.
//   up:   value+STEP > MAX_VAL -> WRAP ? MIN_VAL : MAX_VAL.
//   down: value < MIN_VAL+STEP -> WRAP ? MAX_VAL : MIN_VAL.
//  Saturated step at a bound leaves value unchanged -> changed stays 0;
//   FSM keeps running while the key is held.
//  changed = registered (value_next != value); latency 1 cycle after update.
//  Reset mid-hold: everything returns to reset state.
//   A key still high after rstN release is NOT a press until it falls and rises again;
//   edge regs reset to 1, not 0 — this overrides the "edge regs=0" reset value above.
// CONFIGURATION
//  `STEP_SEL_AUTOREPEAT_EN defined: hold-to-repeat as above.
//  Undefined: FSM, counter and tick logic omitted; tick unused.
//   Exactly one step per press; holding never steps again.
// STRUCTURE
//  Shared package step_sel_pkg: sel_state_t {IDLE, DELAY, REPEAT}; DIR_UP=1'b1, DIR_DN=1'b0.
//  Sub-module rise_edge_det (clk, rstN, in, rise), instantiated for up and down.
//   Its reset value is a parameter, set to 1 here.
//  Next-value/saturation logic inline.
// TESTING  (WIDTH=4, MIN=0, MAX=8, RESET_VAL=3, STEP=1, DELAY=2, PERIOD=1)
//  Reset, then release -> value=3, changed=0, at_min=at_max=0.
//  5 separate up presses, autorepeat off -> 4,5,6,7,8, then stays 8; at_max=1;
//   changed pulses exactly 5 times.
//  WRAP=1, value=8, one up press -> 0.
//   Then one down press -> 8; each update gives a changed pulse.
//  Hold down from 3, autorepeat on -> 2 on the press.
//   -> 1 on the 2nd tick, 0 on the 3rd tick; holds 0 with at_min=1 and no further changed pulse.
//  up and down rise in the same cycle -> value unchanged.
//   sync_clr at value 6 -> 3 next edge, changed pulse.
//  rstN low for 1 cycle mid-REPEAT with up held -> value=3.
//   No step until up falls and rises again.

Source files
------------

// File: rtl/step_sel_pkg.sv
// Shared types for the step level selector.
// Holds FSM states, direction codes and a small helper.
package step_sel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } sel_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a clk-synchronous level.
// Ports: clk, rstN (async low), in (level), rise (1-cycle pulse).
module rise_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            in_q <= RST_VAL;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/step_level_selector.sv
// Bounded up/down level selector stepped by debounced key presses.
// Ports: clk, rstN (async low), tick (repeat pacing strobe), up, down,
//   sync_clr (reload RESET_VAL); value, at_min, at_max, changed (1-cycle pulse).
// Define STEP_SEL_AUTOREPEAT_EN to enable timed hold-to-repeat;
//   without it each press steps exactly once and tick is unused.
module step_level_selector
    import step_sel_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 8,
    parameter int RESET_VAL     = 3,
    parameter int STEP          = 1,
    parameter int WRAP          = 0,
    parameter int REPEAT_DELAY  = 2,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] value,
    output logic             at_min,
    output logic             at_max,
    output logic             changed
);

    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

    logic             up_rise;
    logic             dn_rise;
    logic [WIDTH:0]   val_x;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] val_up;
    logic [WIDTH-1:0] val_dn;
    logic [WIDTH-1:0] value_next;

    // Reset to 1 so a key still held across reset is not seen as a press.
    rise_edge_det #(.RST_VAL(1'b1)) u_up_det (
        .clk  (clk),
        .rstN (rstN),
        .in   (up),
        .rise (up_rise)
    );

    rise_edge_det #(.RST_VAL(1'b1)) u_dn_det (
        .clk  (clk),
        .rstN (rstN),
        .in   (down),
        .rise (dn_rise)
    );

    // One extra bit so value+STEP cannot overflow before the bound test.
    always_comb begin
        val_x  = {1'b0, value};
        sum_up = val_x + STEP_X;
        if (sum_up > MAX_X) begin
            val_up = (WRAP != 0) ? MIN_W : MAX_W;
        end else begin
            val_up = sum_up[WIDTH-1:0];
        end
        if (val_x < (MIN_X + STEP_X)) begin
            val_dn = (WRAP != 0) ? MAX_W : MIN_W;
        end else begin
            val_dn = value - STEP_W;
        end
    end

`ifdef STEP_SEL_AUTOREPEAT_EN

    localparam int CNT_W =
        $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    sel_state_t       state;
    sel_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             dir;
    logic             dir_next;
    logic             held;

    always_comb begin
        value_next = value;
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir;
        held       = (dir == DIR_UP) ? up : down;
        if (sync_clr) begin
            value_next = RST_W;
            state_next = IDLE;
        end else if (up && down) begin
            state_next = IDLE;
        end else if (up_rise || dn_rise) begin
            value_next = up_rise ? val_up : val_dn;
            state_next = DELAY;
            cnt_next   = CNT_W'(REPEAT_DELAY);
            dir_next   = up_rise ? DIR_UP : DIR_DN;
        end else begin
            case (state)
                DELAY, REPEAT: begin
                    if (!held) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        if (cnt == CNT_W'(1)) begin
                            value_next = (dir == DIR_UP) ? val_up : val_dn;
                            cnt_next   = CNT_W'(REPEAT_PERIOD);
                            state_next = REPEAT;
                        end else begin
                            cnt_next = cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= DIR_DN;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dir   <= dir_next;
        end
    end

`else

    logic unused_tick;
    assign unused_tick = tick;

    always_comb begin
        value_next = value;
        if (sync_clr) begin
            value_next = RST_W;
        end else if (up && down) begin
            value_next = value;
        end else if (up_rise) begin
            value_next = val_up;
        end else if (dn_rise) begin
            value_next = val_dn;
        end
    end

`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            value   <= RST_W;
            changed <= 1'b0;
        end else begin
            value   <= value_next;
            changed <= (value_next != value);
        end
    end

    assign at_min = (value == MIN_W);
    assign at_max = (value == MAX_W);

endmodule

// File: tb/tb_step_level_selector.sv
// Scoreboard bench for step_level_selector.
// Two instances: saturating (main) and wrapping.
module tb_step_level_selector;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic tick = 1'b0;
    logic up = 1'b0;
    logic down = 1'b0;
    logic sync_clr = 1'b0;
    logic wup = 1'b0;
    logic wdown = 1'b0;
    logic wclr = 1'b0;

    logic [3:0] value;
    logic       at_min;
    logic       at_max;
    logic       changed;
    logic [3:0] wvalue;
    logic       wat_min;
    logic       wat_max;
    logic       wchanged;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int wpulses = 0;
    int exp_q[$];
    int wexp_q[$];

`ifdef STEP_SEL_AUTOREPEAT_EN
    localparam int HOLD_END = 0;
`else
    localparam int HOLD_END = 2;
`endif

    step_level_selector u_dut (
        .clk      (clk),
        .rstN     (rstN),
        .tick     (tick),
        .up       (up),
        .down     (down),
        .sync_clr (sync_clr),
        .value    (value),
        .at_min   (at_min),
        .at_max   (at_max),
        .changed  (changed)
    );

    step_level_selector #(.WRAP(1)) u_wrap (
        .clk      (clk),
        .rstN     (rstN),
        .tick     (tick),
        .up       (wup),
        .down     (wdown),
        .sync_clr (wclr),
        .value    (wvalue),
        .at_min   (wat_min),
        .at_max   (wat_max),
        .changed  (wchanged)
    );

    always #5 clk = ~clk;

    // Monitor: every changed pulse must match the next queued value.
    always @(negedge clk) begin
        int e;
        if (rstN && changed) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL main_pulse: unexpected pulse, value=%0d", value);
            end else begin
                e = exp_q.pop_front();
                if (int'(value) != e) begin
                    errors++;
                    $display("FAIL main_value: got %0d expected %0d", value, e);
                end
            end
        end
        if (rstN && wchanged) begin
            wpulses++;
            checks++;
            if (wexp_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_pulse: unexpected pulse, value=%0d", wvalue);
            end else begin
                e = wexp_q.pop_front();
                if (int'(wvalue) != e) begin
                    errors++;
                    $display("FAIL wrap_value: got %0d expected %0d", wvalue, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic press(input bit w, input bit dir_up);
        if (w) begin
            if (dir_up) wup = 1'b1; else wdown = 1'b1;
        end else begin
            if (dir_up) up = 1'b1; else down = 1'b1;
        end
        cyc(1);
        wup = 1'b0;
        wdown = 1'b0;
        up = 1'b0;
        down = 1'b0;
        cyc(2);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic clr();
        sync_clr = 1'b1;
        cyc(1);
        sync_clr = 1'b0;
        cyc(2);
    endtask

    initial begin
        int p0;
        cyc(3);
        rstN = 1'b1;
        cyc(2);
        chk("reset_value", int'(value), 3);
        chk("reset_changed", int'(changed), 0);
        chk("reset_at_min", int'(at_min), 0);
        chk("reset_at_max", int'(at_max), 0);

        p0 = pulses;
        for (int i = 4; i <= 8; i++) begin
            exp_q.push_back(i);
            press(1'b0, 1'b1);
        end
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("sat_value", int'(value), 8);
        chk("sat_at_max", int'(at_max), 1);
        chk("up_pulse_count", pulses - p0, 5);

        exp_q.push_back(3);
        clr();
        chk("clr_to_3", int'(value), 3);

        exp_q.push_back(2);
        down = 1'b1;
        cyc(1);
        pulse_tick();
`ifdef STEP_SEL_AUTOREPEAT_EN
        exp_q.push_back(1);
        pulse_tick();
        exp_q.push_back(0);
        pulse_tick();
`else
        pulse_tick();
        pulse_tick();
`endif
        p0 = pulses;
        pulse_tick();
        pulse_tick();
        chk("hold_value", int'(value), HOLD_END);
        chk("hold_at_min", int'(at_min), (HOLD_END == 0) ? 1 : 0);
        chk("hold_no_more_pulse", pulses - p0, 0);
        down = 1'b0;
        cyc(2);

        up = 1'b1;
        down = 1'b1;
        cyc(1);
        pulse_tick();
        up = 1'b0;
        down = 1'b0;
        cyc(2);
        chk("both_rise_value", int'(value), HOLD_END);

        exp_q.push_back(3);
        clr();
        for (int i = 4; i <= 6; i++) begin
            exp_q.push_back(i);
            press(1'b0, 1'b1);
        end
        chk("before_clr_6", int'(value), 6);
        exp_q.push_back(3);
        clr();
        chk("clr_from_6", int'(value), 3);
        p0 = pulses;
        clr();
        chk("clr_same_no_pulse", pulses - p0, 0);

        exp_q.push_back(4);
        up = 1'b1;
        cyc(1);
        pulse_tick();
`ifdef STEP_SEL_AUTOREPEAT_EN
        exp_q.push_back(5);
`endif
        pulse_tick();
        rstN = 1'b0;
        cyc(1);
        chk("mid_reset_value", int'(value), 3);
        rstN = 1'b1;
        cyc(1);
        p0 = pulses;
        pulse_tick();
        pulse_tick();
        pulse_tick();
        chk("held_after_reset", int'(value), 3);
        chk("held_after_reset_pulses", pulses - p0, 0);
        up = 1'b0;
        cyc(1);
        exp_q.push_back(4);
        press(1'b0, 1'b1);
        chk("repress_after_reset", int'(value), 4);

        for (int i = 4; i <= 8; i++) begin
            wexp_q.push_back(i);
            press(1'b1, 1'b1);
        end
        chk("wrap_at_max", int'(wat_max), 1);
        wexp_q.push_back(0);
        press(1'b1, 1'b1);
        chk("wrap_up_to_min", int'(wvalue), 0);
        chk("wrap_at_min", int'(wat_min), 1);
        wexp_q.push_back(8);
        press(1'b1, 1'b0);
        chk("wrap_down_to_max", int'(wvalue), 8);
        chk("wrap_pulse_count", wpulses, 7);

        cyc(3);
        chk("main_queue_empty", exp_q.size(), 0);
        chk("wrap_queue_empty", wexp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
